// File: rtl/interpolation_result_reader.sv
// Streams a block of result words from the registered-read RAM to the consumer; first word valid 2 cycles after Start.
// Reads are throttled so buffered plus in-flight words never exceed the 2-entry buffer; Out_Ready low stalls reads.
module interpolation_result_reader #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64,
    parameter int RAM_DEPTH         = 50
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Start,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Base_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Word_Count,
    output logic                         RAM_RD_Enable,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD_Address,
    input  logic [DATA_WIDTH-1:0]        RAM_RD_Data,
    output logic [DATA_WIDTH-1:0]        Out_Data,
    output logic                         Out_Valid,
    input  logic                         Out_Ready,
    output logic                         Out_Last,
    output logic                         Busy,
    output logic                         Done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                         state;
    logic [RAM_ADDRESS_WIDTH-1:0]   addr;
    logic [RAM_ADDRESS_WIDTH-1:0]   remaining;
    logic [RAM_ADDRESS_WIDTH-1:0]   addr_next;
    logic                           rd_pend;
    logic                           rd_pend_last;
    logic [DATA_WIDTH-1:0]          buf_dat [2];
    logic                           buf_last [2];
    logic                           rd_ptr;
    logic                           wr_ptr;
    logic [1:0]                     occ;
    logic [2:0]                     fill;
    logic                           pop;
    logic                           last_req;
    logic                           busy_q;
    logic                           done_q;

    assign Out_Valid      = (occ != 2'd0);
    assign Out_Data       = Out_Valid ? buf_dat[rd_ptr] : '0;
    assign Out_Last       = Out_Valid && buf_last[rd_ptr];
    assign pop            = Out_Valid && Out_Ready;
    assign Busy           = busy_q;
    assign Done           = done_q;
    assign RAM_RD_Address = addr;

    // Words that will sit in the buffer after this edge if no new read is issued.
    assign fill = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};

    assign RAM_RD_Enable = (state == S_READ) && (remaining != '0) && (fill < 3'd2);
    assign last_req      = RAM_RD_Enable && (remaining == RAM_ADDRESS_WIDTH'(1));
    assign addr_next     = (addr == RAM_ADDRESS_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                                       : addr + RAM_ADDRESS_WIDTH'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_IDLE;
            addr         <= '0;
            remaining    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            occ          <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_dat[i]  <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            rd_pend      <= RAM_RD_Enable;
            rd_pend_last <= last_req;

            if (rd_pend) begin
                buf_dat[wr_ptr]  <= RAM_RD_Data;
                buf_last[wr_ptr] <= rd_pend_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, rd_pend} - {1'b0, pop};

            if (RAM_RD_Enable) begin
                addr      <= addr_next;
                remaining <= remaining - RAM_ADDRESS_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        addr      <= Base_Address;
                        remaining <= Word_Count;
                        busy_q    <= 1'b1;
                        if (Word_Count == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (last_req) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && Out_Last) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
